pong_game_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 17 +
 rtl/pong_btn_edge.sv | 13 +
 rtl/pong_game_ctrl.sv | 132 +++++++++++++
 tb/tb_pong_game_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, screen geometry and serve park positions.
package pong_pkg;
  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } pong_state_t;
  localparam logic [9:0] SCREEN_H  = 10'd480;
  localparam logic [9:0] BALL_SIZE = 10'd10;
  localparam logic [9:0] SERVE_XL  = 10'd65;
  localparam logic [9:0] SERVE_XR  = 10'd575;
  localparam logic [8:0] SERVE_Y   = 9'd240;
  function automatic logic [9:0] park_x(input logic side);
    return side ? SERVE_XR : SERVE_XL;
  endfunction
endpackage

// File: rtl/pong_btn_edge.sv
// pong_btn_edge: one-cycle pulse on the rising edge of a level input.
module pong_btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic lvl,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev <= 1'b0;
    else prev <= lvl;
  assign rise = lvl & ~prev;
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: ball motion, wall bounces, serve handoff, scoring and game-over sequencing.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter logic [9:0] X_STEP       = 10'd8,
  parameter logic [9:0] Y_STEP       = 10'd4,
  parameter logic [9:0] LEFT_MISS    = 10'd16,
  parameter logic [9:0] RIGHT_MISS   = 10'd624,
  parameter int         PAUSE_FRAMES = 60,
  parameter logic [3:0] WIN_SCORE    = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       p1_srv,
  input  logic       p2_srv,
  input  logic       p1_hit,
  input  logic       p2_hit,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] state,
  output logic       serve_side
);
  localparam int CW = $clog2(PAUSE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PAUSE_FRAMES - 1);
  localparam logic [9:0] Y_MAX = SCREEN_H - BALL_SIZE;
  pong_state_t st, st_n;
  logic p1_edge, p2_edge, dx, dx_n, dy, dy_n, dx_eff, side_n, park, miss_l, miss_r;
  logic [9:0] x_n, y10, y_up, y_dn;
  logic [8:0] y_n;
  logic [3:0] s1_n, s2_n, s1_inc, s2_inc;
  logic [CW-1:0] cnt, cnt_n;
  pong_btn_edge u_p1_edge (.clk(clk), .rst_n(rst_n), .lvl(p1_srv), .rise(p1_edge));
  pong_btn_edge u_p2_edge (.clk(clk), .rst_n(rst_n), .lvl(p2_srv), .rise(p2_edge));
  assign state = st;
  always_comb begin
    dx_eff = p1_hit ? 1'b1 : p2_hit ? 1'b0 : dx;
    y10    = {1'b0, ball_y};
    y_up   = y10 - Y_STEP;
    y_dn   = y10 + Y_STEP;
    s1_inc = (score_p1 == WIN_SCORE) ? score_p1 : score_p1 + 4'd1;
    s2_inc = (score_p2 == WIN_SCORE) ? score_p2 : score_p2 + 4'd1;
    miss_l = frame_tick && !dx_eff && ball_x < LEFT_MISS + X_STEP;
    miss_r = frame_tick && dx_eff && ball_x > RIGHT_MISS - X_STEP;
    st_n   = st;
    x_n    = ball_x;
    y_n    = ball_y;
    s1_n   = score_p1;
    s2_n   = score_p2;
    side_n = serve_side;
    dx_n   = dx;
    dy_n   = dy;
    cnt_n  = cnt;
    park   = 1'b0;
    case (st)
      ST_SERVE: begin
        park = 1'b1;
        if (serve_side ? p2_edge : p1_edge) begin
          st_n = ST_PLAY;
          dx_n = ~serve_side;
        end
      end
      ST_PLAY: begin
        dx_n = dx_eff;
        if (miss_l) begin
          s2_n   = s2_inc;
          side_n = 1'b0;
          st_n   = (s2_inc == WIN_SCORE) ? ST_OVER : ST_POINT;
        end else if (miss_r) begin
          s1_n   = s1_inc;
          side_n = 1'b1;
          st_n   = (s1_inc == WIN_SCORE) ? ST_OVER : ST_POINT;
        end else if (frame_tick) begin
          x_n = dx_eff ? ball_x + X_STEP : ball_x - X_STEP;
          if (!dy && y10 < Y_STEP) begin
            y_n  = 9'd0;
            dy_n = 1'b1;
          end else if (dy && y_dn + BALL_SIZE > SCREEN_H) begin
            y_n  = Y_MAX[8:0];
            dy_n = 1'b0;
          end else y_n = dy ? y_dn[8:0] : y_up[8:0];
        end
      end
      ST_POINT: if (frame_tick) begin
        cnt_n = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          st_n  = ST_SERVE;
          park  = 1'b1;
          dy_n  = ~dy;
        end
      end
      default: if (p1_edge || p2_edge) begin
        s1_n   = 4'd0;
        s2_n   = 4'd0;
        side_n = ~p1_edge;
        st_n   = ST_SERVE;
        park   = 1'b1;
        dy_n   = ~dy;
      end
    endcase
    // the vertical direction flips each time a fresh serve is set up, so rallies alternate up/down starts
    if (park) begin
      x_n = park_x(side_n);
      y_n = SERVE_Y;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st         <= ST_SERVE;
      serve_side <= 1'b1;
      ball_x     <= SERVE_XR;
      ball_y     <= SERVE_Y;
      score_p1   <= 4'd0;
      score_p2   <= 4'd0;
      dx         <= 1'b0;
      dy         <= 1'b1;
      cnt        <= '0;
    end else begin
      st         <= st_n;
      serve_side <= side_n;
      ball_x     <= x_n;
      ball_y     <= y_n;
      score_p1   <= s1_n;
      score_p2   <= s2_n;
      dx         <= dx_n;
      dy         <= dy_n;
      cnt        <= cnt_n;
    end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed game scenarios checked against a frame-level behavioural model.
module tb_pong_game_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0;
  logic p1_srv = 1'b0, p2_srv = 1'b0, p1_hit = 1'b0, p2_hit = 1'b0;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] score_p1, score_p2;
  logic [1:0] state;
  logic serve_side;
  int n_chk = 0, n_fail = 0;
  logic chk_en = 1'b0;
  typedef struct {
    int x, y, s1, s2, st, side, dx, dy, cnt, p1p, p2p;
  } mdl_t;
  mdl_t m;
  pong_game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .p1_srv(p1_srv), .p2_srv(p2_srv),
    .p1_hit(p1_hit), .p2_hit(p2_hit), .ball_x(ball_x), .ball_y(ball_y), .score_p1(score_p1),
    .score_p2(score_p2), .state(state), .serve_side(serve_side)
  );
  always #5 clk = ~clk;
  function automatic mdl_t mrst();
    mdl_t r;
    r = '{x: 575, y: 240, s1: 0, s2: 0, st: 0, side: 1, dx: -1, dy: 1, cnt: 0, p1p: 0, p2p: 0};
    return r;
  endfunction
  function automatic mdl_t new_serve(input mdl_t c);
    mdl_t n = c;
    n.st = 0;
    n.dy = -c.dy;
    n.x = c.side ? 575 : 65;
    n.y = 240;
    return n;
  endfunction
  function automatic mdl_t step(input mdl_t c, input logic ft, b1, b2, h1, h2);
    mdl_t n = c;
    int ny;
    logic e1, e2;
    e1 = b1 && c.p1p == 0;
    e2 = b2 && c.p2p == 0;
    n.p1p = int'(b1);
    n.p2p = int'(b2);
    if (c.st == 0) begin
      if (c.side == 1 ? e2 : e1) begin
        n.st = 1;
        n.dx = c.side == 1 ? -1 : 1;
      end
    end else if (c.st == 1) begin
      n.dx = h1 ? 1 : h2 ? -1 : c.dx;
      if (ft) begin
        if (n.dx < 0 && c.x - 8 < 16) begin
          n.s2 = c.s2 + 1 > 9 ? 9 : c.s2 + 1;
          n.side = 0;
          n.st = n.s2 == 9 ? 3 : 2;
        end else if (n.dx > 0 && c.x + 8 > 624) begin
          n.s1 = c.s1 + 1 > 9 ? 9 : c.s1 + 1;
          n.side = 1;
          n.st = n.s1 == 9 ? 3 : 2;
        end else begin
          n.x = c.x + 8 * n.dx;
          ny = c.y + 4 * c.dy;
          if (ny < 0) begin n.y = 0; n.dy = 1; end
          else if (ny + 10 > 480) begin n.y = 470; n.dy = -1; end
          else n.y = ny;
        end
      end
    end else if (c.st == 2) begin
      if (ft) begin
        n.cnt = c.cnt + 1;
        if (n.cnt == 60) begin n.cnt = 0; n = new_serve(n); end
      end
    end else if (e1 || e2) begin
      n.s1 = 0;
      n.s2 = 0;
      n.side = e1 ? 0 : 1;
      n = new_serve(n);
    end
    return n;
  endfunction
  always @(posedge clk or negedge rst_n)
    m <= !rst_n ? mrst() : step(m, frame_tick, p1_srv, p2_srv, p1_hit, p2_hit);
  always @(negedge clk)
    if (chk_en) begin
      n_chk++;
      if (ball_x !== 10'(m.x) || ball_y !== 9'(m.y) || score_p1 !== 4'(m.s1) || score_p2 !== 4'(m.s2) ||
          state !== 2'(m.st) || serve_side !== 1'(m.side)) begin
        n_fail++;
        $display("FAIL model t=%0t got x=%0d y=%0d s1=%0d s2=%0d st=%0d side=%0d want x=%0d y=%0d s1=%0d s2=%0d st=%0d side=%0d",
                 $time, ball_x, ball_y, score_p1, score_p2, state, serve_side, m.x, m.y, m.s1, m.s2, m.st, m.side);
      end
    end
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic tick(input logic h1, input logic h2);
    @(posedge clk); #1;
    frame_tick = 1'b1; p1_hit = h1; p2_hit = h2;
    @(posedge clk); #1;
    frame_tick = 1'b0; p1_hit = 1'b0; p2_hit = 1'b0;
  endtask
  task automatic press(input int who);
    @(posedge clk); #1;
    if (who == 1) p1_srv = 1'b1; else p2_srv = 1'b1;
    @(posedge clk); #1;
    p1_srv = 1'b0; p2_srv = 1'b0;
  endtask
  task automatic rally();
    int n = 0;
    while (m.st == 1 && n < 400) begin
      tick(m.x < 40 && m.dx < 0, 1'b0);
      n++;
    end
    chk("rally_ends", int'(m.st != 1), 1);
  endtask
  task automatic pause();
    int n = 0;
    while (m.st == 2 && n < 100) begin
      tick(1'b0, 1'b0);
      n++;
    end
    chk("pause_len", n, 60);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_state", int'(state), 0);
    chk("rst_x", int'(ball_x), 575);
    chk("rst_y", int'(ball_y), 240);
    chk("rst_side", int'(serve_side), 1);
    chk("rst_scores", int'({score_p1, score_p2}), 0);
    rst_n = 1'b1;
    press(1);
    chk("p1_ignored", int'(state), 0);
    press(2);
    chk("serve_play", int'(state), 1);
    for (int i = 1; i <= 300 && m.st == 1; i++) begin
      tick(i == 69, i == 69 || i == 142);
      if (i == 1) begin chk("t1_x", int'(ball_x), 567); chk("t1_y", int'(ball_y), 244); end
      if (i == 57) chk("t57_y", int'(ball_y), 468);
      if (i == 58) chk("t58_y_clamp", int'(ball_y), 470);
      if (i == 59) chk("t59_y_up", int'(ball_y), 466);
      if (i == 69) chk("both_hits_right", int'(ball_x), 39);
      if (i == 142) chk("p2_hit_left", int'(ball_x), 607);
      if (i == 175) chk("t175_y", int'(ball_y), 2);
      if (i == 176) chk("t176_y_top", int'(ball_y), 0);
      if (i == 177) chk("t177_y_down", int'(ball_y), 4);
      if (i == 216) begin
        chk("miss_s2", int'(score_p2), 1);
        chk("miss_state", int'(state), 2);
        chk("miss_side", int'(serve_side), 0);
        chk("miss_frozen_x", int'(ball_x), 23);
        chk("miss_frozen_y", int'(ball_y), 156);
      end
    end
    press(1);
    chk("point_press_ignored", int'(state), 2);
    for (int i = 1; i <= 60; i++) begin
      tick(1'b1, 1'b0);
      if (i == 59) chk("point_hold", int'(state), 2);
    end
    chk("point_done", int'(state), 0);
    chk("park_x", int'(ball_x), 65);
    chk("park_y", int'(ball_y), 240);
    for (int r = 0; r < 9; r++) begin
      press(m.side == 1 ? 2 : 1);
      if (r == 8) p1_srv = 1'b1;
      rally();
      chk("score_p1", int'(score_p1), r + 1);
      if (r < 8) pause();
    end
    chk("over_state", int'(state), 3);
    repeat (3) tick(1'b0, 1'b0);
    chk("over_frozen_x", int'(ball_x), 623);
    chk("over_held", int'(state), 3);
    chk("over_s2", int'(score_p2), 1);
    p1_srv = 1'b0;
    repeat (2) @(posedge clk);
    press(1);
    chk("restart_state", int'(state), 0);
    chk("restart_scores", int'({score_p1, score_p2}), 0);
    chk("restart_side", int'(serve_side), 0);
    chk("restart_x", int'(ball_x), 65);
    press(1);
    repeat (3) tick(1'b0, 1'b0);
    chk("p1_serve_x", int'(ball_x), 89);
    @(posedge clk); #1;
    p2_hit = 1'b1;
    @(posedge clk); #1;
    p2_hit = 1'b0;
    tick(1'b0, 1'b0);
    chk("hit_no_tick", int'(ball_x), 81);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_x", int'(ball_x), 575);
    chk("async_y", int'(ball_y), 240);
    chk("async_side", int'(serve_side), 1);
    #20;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
